// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE/ACCESS/CAPTURE)
//   PORT_CPU    : port id of the CPU load/store unit
//   PORT_DMA    : port id of the DMA/loader
//   ALIGN_MASK  : byte-offset bits that must be zero for a word access
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, reset : clock, asynchronous active-high reset
//   req[1:0]   : eligible requests
//   advance    : the current grant is being taken; remember its winner
//   grant[1:0] : one-hot winner, or zero when no request
// The port that did not win last time wins a tie. Reset leaves last_grant = 1,
// so port 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            r_last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data_memory between the CPU (port 0)
// and the DMA/loader (port 1). One access at a time, IDLE -> ACCESS -> CAPTURE.
//   clk, reset              : clock, asynchronous active-high reset
//   reqN/weN/addrN/wdataN   : requester N command, held until doneN
//   doneN/errN/rdataN       : one-cycle completion, error flag, read data
//   mem_*                   : strobes, address and data to/from data_memory
// Optional macro DMEM_ARB_STATS_EN adds grant_cnt0/grant_cnt1/err_cnt counters.
// All outputs are registered.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 256,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]       grant_cnt0,
    output logic [31:0]       grant_cnt1,
    output logic [15:0]       err_cnt,
`endif
    input  logic [31:0]       mem_read_data
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_SIZE * 4 - 4);

    arb_state_e        r_state, w_state;
    logic              r_port, w_port;
    logic              r_we, w_we;
    logic              r_err, w_err;
    logic              r_done0, w_done0, r_done1, w_done1;
    logic              r_err0, w_err0, r_err1, w_err1;
    logic [31:0]       r_rdata0, w_rdata0, r_rdata1, w_rdata1;
    logic [ADDR_W-1:0] r_mem_address, w_mem_address;
    logic [31:0]       r_mem_wdata, w_mem_wdata;
    logic              r_mem_read, w_mem_read, r_mem_write, w_mem_write;

    logic [1:0]        w_elig, w_grant;
    logic              w_sel_port, w_sel_we, w_legal;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;

    // A port is masked during its own done cycle so a held req is not regranted.
    assign w_elig = (r_state == IDLE) ? {req1 & ~r_done1, req0 & ~r_done0} : 2'b00;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (w_elig),
        .advance (r_state == IDLE),
        .grant   (w_grant)
    );

    assign w_sel_port  = w_grant[1] ? PORT_DMA : PORT_CPU;
    assign w_sel_we    = (w_sel_port == PORT_DMA) ? we1 : we0;
    assign w_sel_addr  = (w_sel_port == PORT_DMA) ? addr1 : addr0;
    assign w_sel_wdata = (w_sel_port == PORT_DMA) ? wdata1 : wdata0;
    assign w_legal     = ((w_sel_addr[1:0] & ALIGN_MASK) == 2'b00) && (w_sel_addr <= ADDR_MAX);

    always_comb begin
        w_state       = r_state;
        w_port        = r_port;
        w_we          = r_we;
        w_err         = r_err;
        w_done0       = 1'b0;
        w_done1       = 1'b0;
        w_err0        = 1'b0;
        w_err1        = 1'b0;
        w_rdata0      = r_rdata0;
        w_rdata1      = r_rdata1;
        w_mem_address = r_mem_address;
        w_mem_wdata   = r_mem_wdata;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant != 2'b00) begin
                    w_port = w_sel_port;
                    w_we   = w_sel_we;
                    w_err  = !w_legal;
                    if (w_legal) begin
                        w_mem_address = w_sel_addr;
                        w_mem_wdata   = w_sel_wdata;
                        w_mem_read    = !w_sel_we;
                        w_mem_write   = w_sel_we;
                        w_state       = ACCESS;
                    end else begin
                        w_state = CAPTURE;
                    end
                end
            end
            ACCESS: begin
                w_state = CAPTURE;
            end
            CAPTURE: begin
                if (r_port == PORT_DMA) begin
                    w_done1 = 1'b1;
                    w_err1  = r_err;
                    if (!r_err && !r_we) w_rdata1 = mem_read_data;
                end else begin
                    w_done0 = 1'b1;
                    w_err0  = r_err;
                    if (!r_err && !r_we) w_rdata0 = mem_read_data;
                end
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_port        <= PORT_CPU;
            r_we          <= 1'b0;
            r_err         <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_err0        <= 1'b0;
            r_err1        <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_port        <= w_port;
            r_we          <= w_we;
            r_err         <= w_err;
            r_done0       <= w_done0;
            r_done1       <= w_done1;
            r_err0        <= w_err0;
            r_err1        <= w_err1;
            r_rdata0      <= w_rdata0;
            r_rdata1      <= w_rdata1;
            r_mem_address <= w_mem_address;
            r_mem_wdata   <= w_mem_wdata;
            r_mem_read    <= w_mem_read;
            r_mem_write   <= w_mem_write;
        end
    end

    assign done0          = r_done0;
    assign done1          = r_done1;
    assign err0           = r_err0;
    assign err1           = r_err1;
    assign rdata0         = r_rdata0;
    assign rdata1         = r_rdata1;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_wdata;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_grant_cnt0, r_grant_cnt1;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_err_cnt    <= '0;
        end else if (w_grant != 2'b00) begin
            if (w_grant[0]) r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            if (w_grant[1]) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
            if (!w_legal && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign err_cnt    = r_err_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// data_memory (registered read, word-indexed).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1, mem_read, mem_write;
    logic [31:0] rdata0, rdata1, mem_address, mem_write_data;
    logic [31:0] mem_read_data = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] grant_cnt0, grant_cnt1;
    logic [15:0] err_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int n_rd  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_SIZE(256), .ADDR_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (req0),
        .req1           (req1),
        .we0            (we0),
        .we1            (we1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .done0          (done0),
        .done1          (done1),
        .err0           (err0),
        .err1           (err1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
`ifdef DMEM_ARB_STATS_EN
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1),
        .err_cnt        (err_cnt),
`endif
        .mem_read_data  (mem_read_data)
    );

    // Behavioural data_memory.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
        if (mem_read) mem_read_data <= mem[mem_address[9:2]];
    end

    // Strobe monitor: counts strobe cycles and flags any read/write overlap.
    always @(negedge clk) begin
        if (mem_write) n_wr = n_wr + 1;
        if (mem_read) n_rd = n_rd + 1;
        if (mem_read && mem_write) begin
            n_bad = n_bad + 1;
            $display("FAIL strobe_overlap: mem_read=%b mem_write=%b required not both 1",
                     mem_read, mem_write);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One access on one port; lat = negedges from request to done (-1 on timeout).
    task automatic do_access(input logic p, input logic we, input logic [31:0] a,
                             input logic [31:0] d, output int lat, output logic e,
                             output logic [31:0] rd, output int nw, output int nr);
        @(negedge clk);
        n_wr = 0;
        n_rd = 0;
        if (p) begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (p ? done1 : done0) begin
                lat = c;
                break;
            end
        end
        e  = p ? err1 : err0;
        rd = p ? rdata1 : rdata0;
        nw = n_wr;
        nr = n_rd;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Both ports write at once; check who finishes first and the 3-cycle spacing.
    task automatic tie_pair(input logic exp_first, input string name);
        int   c_first, c_second, seen;
        logic first;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd16; wdata0 = 32'hA0A0_0000;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd20; wdata1 = 32'hB1B1_0000;
        c_first = -1; c_second = -1; seen = 0; first = 1'b0;
        for (int c = 1; c <= 20 && seen < 2; c++) begin
            @(negedge clk);
            if (done0 || done1) begin
                if (seen == 0) begin
                    first = done1;
                    c_first = c;
                end else begin
                    c_second = c;
                end
                seen = seen + 1;
                if (done0) req0 = 1'b0;
                if (done1) req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check({name, "_first_port"}, {31'd0, first}, {31'd0, exp_first});
        check({name, "_first_lat"}, c_first, 32'd3);
        check({name, "_second_gap"}, c_second - c_first, 32'd3);
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_nw;
        int          exp_nr;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int          lat, nw, nr, seen, saw_done;
        logic        e, exp_port;
        logic [31:0] rd;

        vecs[0]  = '{1'b0, 1'b1, 32'd4,         32'h00FF_00FF, 1'b0, 3, 32'h0000_0000, 1, 0};
        vecs[1]  = '{1'b0, 1'b0, 32'd4,         32'h0,         1'b0, 3, 32'h00FF_00FF, 0, 1};
        vecs[2]  = '{1'b1, 1'b1, 32'd1020,      32'hDEAD_BEEF, 1'b0, 3, 32'h0000_0000, 1, 0};
        vecs[3]  = '{1'b1, 1'b0, 32'd1020,      32'h0,         1'b0, 3, 32'hDEAD_BEEF, 0, 1};
        vecs[4]  = '{1'b1, 1'b0, 32'd6,         32'h0,         1'b1, 2, 32'hDEAD_BEEF, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 32'd1024,      32'h0,         1'b1, 2, 32'hDEAD_BEEF, 0, 0};
        vecs[6]  = '{1'b0, 1'b1, 32'd1,         32'hFFFF_FFFF, 1'b1, 2, 32'h00FF_00FF, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 32'd1020,      32'h0,         1'b0, 3, 32'hDEAD_BEEF, 0, 1};
        vecs[8]  = '{1'b1, 1'b1, 32'd8,         32'h1234_5678, 1'b0, 3, 32'hDEAD_BEEF, 1, 0};
        vecs[9]  = '{1'b0, 1'b0, 32'd8,         32'h0,         1'b0, 3, 32'h1234_5678, 0, 1};
        vecs[10] = '{1'b0, 1'b1, 32'd12,        32'h1111_1111, 1'b0, 3, 32'h1234_5678, 1, 0};
        vecs[11] = '{1'b1, 1'b1, 32'd2,         32'h5555_5555, 1'b1, 2, 32'hDEAD_BEEF, 0, 0};
        vecs[12] = '{1'b0, 1'b0, 32'h1000_0000, 32'h0,         1'b1, 2, 32'h1234_5678, 0, 0};

        // Reset state.
        @(negedge clk);
        check("reset_outputs", {28'd0, done0, done1, err0, err1}, 32'd0);
        check("reset_rdata", rdata0 | rdata1, 32'd0);
        check("reset_mem_if", mem_address | mem_write_data | {30'd0, mem_read, mem_write},
              32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First tie goes to port 0, then 1. A lone port 0 grant leaves port 1 next.
        tie_pair(1'b0, "tie_after_reset");
        do_access(1'b0, 1'b1, 32'd24, 32'h0, lat, e, rd, nw, nr);
        check("lone_p0_lat", lat, 32'd3);
        tie_pair(1'b1, "tie_repeat");

        // Table-driven single-port accesses.
        for (int i = 0; i < 13; i++) begin
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, e, rd, nw, nr);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_wr_cycles", i), nw, vecs[i].exp_nw);
            check($sformatf("v%0d_rd_cycles", i), nr, vecs[i].exp_nr);
        end

        // Continuous contention: last grant was port 0, so port 1 leads.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd8;
        seen = 0;
        exp_port = 1'b1;
        for (int c = 0; c < 60 && seen < 12; c++) begin
            @(negedge clk);
            if (done0 || done1) begin
                check($sformatf("alt%0d_port", seen), {30'd0, done1, done0},
                      exp_port ? 32'd2 : 32'd1);
                exp_port = ~exp_port;
                seen = seen + 1;
                if (seen == 12) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("alt_count", seen, 32'd12);

        // Reset during the ACCESS cycle of a port 0 write.
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd12; wdata0 = 32'hAAAA_5555;
        @(negedge clk);
        check("abort_strobe_before", {31'd0, mem_write}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_strobe_after", {31'd0, mem_write}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done0) saw_done = 1;
        end
        check("abort_no_done", saw_done, 32'd0);
        tie_pair(1'b0, "tie_after_abort");
        do_access(1'b0, 1'b0, 32'd12, 32'h0, lat, e, rd, nw, nr);
        check("abort_mem_intact", rd, 32'h1111_1111);

`ifdef DMEM_ARB_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_access(1'b0, 1'b1, 32'd16, 32'h1, lat, e, rd, nw, nr);
        do_access(1'b0, 1'b0, 32'd16, 32'h0, lat, e, rd, nw, nr);
        do_access(1'b0, 1'b1, 32'd3,  32'h2, lat, e, rd, nw, nr);
        do_access(1'b1, 1'b1, 32'd20, 32'h3, lat, e, rd, nw, nr);
        do_access(1'b1, 1'b0, 32'd20, 32'h0, lat, e, rd, nw, nr);
        @(negedge clk);
        check("stats_grant_cnt0", grant_cnt0, 32'd3);
        check("stats_grant_cnt1", grant_cnt1, 32'd2);
        check("stats_err_cnt", {16'd0, err_cnt}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
